inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Decoupling FIFO between the second fetch stage (cache-trace, fed by inst_data_ok) and decode.
- Accepts one fetch packet of up to 4 instructions per cycle, compacts the enabled lanes, and stores them with PC, exception and prediction sidebands.
- Presents up to 2 in-order instructions per cycle to decode.
- A pipeline-wide cancel empties it in one cycle.

Parameters:
- DEPTH, 16, number of instruction entries; power of two, ≥ 8.
- PTR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- SCT_valid_i  in  1  fetch packet valid this cycle (already gated by inst_data_ok and its cancel flag).
- SCT_originEnable_i  in  4  lane enable mask; arbitrary pattern.
- SCT_VAddr_i  in  32  packet virtual address; lane i PC = {VAddr[31:4], i[1:0], 2'b00}.
- SCT_hasException_i  in  1  fetch exception for the packet.
- SCT_ExcCode_i  in  5  exception code.
- SCT_isRefill_i  in  1  TLB refill flavour.
- SCT_predTake_p_i  in  4  per-lane predicted taken.
- SCT_predDest_p_i  in  128  per-lane predicted target; lane i = bits [32i+31:32i].
- inst_rdata_i  in  128  4 instruction words; lane i = bits [32i+31:32i].
- flush_w_i  in  1  OR of branch-check cancel, CP0 exception and SBA flush.
- ID_allowin_w_i  in  1  decode accepts the presented pair this cycle.
- IQ_allowin_w_o  out  1  free entries ≥ 4 (registered-count based).
- IQ_valid_o  out  2  bit0: slot0 valid; bit1: slot1 valid.
- IQ_inst_o  out  64  slot0 = [31:0], slot1 = [63:32].
- IQ_pc_o  out  64  PCs, same slot layout.
- IQ_hasException_o  out  2  per-slot exception.
- IQ_ExcCode_o  out  10  slot0 = [4:0], slot1 = [9:5].
- IQ_isRefill_o  out  2  per-slot refill.
- IQ_predTake_o  out  2  per-slot predicted taken.
- IQ_predDest_o  out  64  per-slot predicted target.

Behaviour:
- Storage: circular buffer of DEPTH entries {inst, pc, hasExc, excCode, isRefill, predTake, predDest}.
  - Registers: head, tail (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).
- Reset (rst = 0, async): head = tail = count = 0.
  - All outputs read as 0 while empty (IQ_valid_o = 0, data buses zero-masked); IQ_allowin_w_o = 1.
- Enqueue: when SCT_valid_i && IQ_allowin_w_o && !flush_w_i.
  - Normal packet: enabled lanes are written in ascending lane order to tail, tail+1, ..., using prefix popcount of the mask for the slot offset. tail += popcount; mask 0 writes nothing.
  - Exception packet (SCT_hasException_i = 1): exactly one entry for lane VAddr[3:2], with inst = 0, hasExc = 1, code and isRefill copied, predTake = 0. Other lanes are dropped.
- Presentation: first-word-fall-through, combinational from head.
  - slot0 = entry[head], slot1 = entry[head+1].
  - IQ_valid_o = {count ≥ 2, count ≥ 1}. Invalid slots drive zero data.
- Dequeue: when ID_allowin_w_i && !flush_w_i, head += popcount(IQ_valid_o). Decode takes all presented valid slots or none.
- Count update: count_next = count + enq_n − deq_n. Enqueue and dequeue in the same cycle are legal.
  - Allowin uses registered count only, so freed space is visible the next cycle.
- Flush: flush_w_i = 1 sets head = tail = count = 0 next edge. Flush has priority over the same-cycle enqueue and dequeue; no write to the array is required.
- Full: count = DEPTH is reachable only via allowin semantics; at count > DEPTH−4 allowin = 0.
- Upstream guarantees it does not assert SCT_valid_i while IQ_allowin_w_o = 0. If it does, the packet is ignored, which is a verification assertion failure.
- Wrap-around: pointer arithmetic in PTR_W bits, including a 4-entry write straddling DEPTH−1 → 0.
- Latency: an enqueued instruction is visible on slot0 the cycle after the write edge at the earliest.
- Reset mid-operation: asynchronous clear; contents become don't-care.

Decomposition:
- Shared defines header: ICode widths (SINGLE_WORD, EXCCODE, INST_NUM), NOEXCCODE, ZEROWORD, TRUE/FALSE, IQ_DEPTH.
- One natural sub-module: inst_queue_compact. It is combinational, turning a 4-bit mask into per-lane write offsets and a popcount, and is reused by decode-side counting.
- Storage is a flat register array; no RAM macro.

Test Plan:
- Reset, then packet VAddr=0x1000, mask 4'b1111, ID_allowin=0 → next cycle IQ_valid_o=2'b11, pc slot0=0x1000, slot1=0x1004, count=4.
- Mask 4'b1010 at VAddr=0x2000 into empty queue → slot0 pc 0x2004 with inst lane1; slot1 pc 0x200C with inst lane3; count=2.
- Fill to count=13 → IQ_allowin_w_o=0. Dequeue 2 → allowin returns 1 only the following cycle (count=11).
- Exception packet VAddr=0x3008, ExcCode=5'h02, isRefill=1, mask 4'b1111 → single entry pc 0x3008, hasExc=1, inst=0, count +1.
- flush_w_i together with a valid packet and ID_allowin=1 at count=6 → next cycle count=0, IQ_valid_o=0, packet not stored.
- Stream packets with random masks and random ID_allowin across ≥ 3 wraps of DEPTH=16 → output PC/inst order matches a scoreboard model exactly; no loss or duplication.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared widths, constants and the stored entry layout for the instruction queue.
// Imported by the queue top and its lane-compaction helper.
package inst_queue_pkg;

    localparam int SINGLE_WORD = 32;
    localparam int EXCCODE     = 5;
    localparam int INST_NUM    = 4;
    localparam int IQ_DEPTH    = 16;

    localparam logic [EXCCODE-1:0]     NOEXCCODE = '0;
    localparam logic [SINGLE_WORD-1:0] ZEROWORD  = '0;
    localparam logic                   TRUE      = 1'b1;
    localparam logic                   FALSE     = 1'b0;

    typedef struct packed {
        logic [SINGLE_WORD-1:0] inst;
        logic [SINGLE_WORD-1:0] pc;
        logic                   has_exc;
        logic [EXCCODE-1:0]     exc_code;
        logic                   is_refill;
        logic                   pred_take;
        logic [SINGLE_WORD-1:0] pred_dest;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_compact.sv
// Turns a 4-lane enable mask into per-lane compacted slot offsets (prefix popcount)
// and the total number of enabled lanes.
module inst_queue_compact
    import inst_queue_pkg::*;
(
    input  logic [INST_NUM-1:0]      mask,
    output logic [INST_NUM-1:0][1:0] offset,
    output logic [2:0]               total
);

    logic [2:0] run;

    always_comb begin
        run    = '0;
        offset = '0;
        for (int i = 0; i < INST_NUM; i++) begin
            offset[i] = run[1:0];
            run       = run + {2'b00, mask[i]};
        end
        total = run;
    end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode decoupling FIFO: compacts up to 4 lanes per cycle into a circular
// buffer and presents up to 2 in-order instructions, first-word-fall-through.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         SCT_valid_i,
    input  logic [3:0]   SCT_originEnable_i,
    input  logic [31:0]  SCT_VAddr_i,
    input  logic         SCT_hasException_i,
    input  logic [4:0]   SCT_ExcCode_i,
    input  logic         SCT_isRefill_i,
    input  logic [3:0]   SCT_predTake_p_i,
    input  logic [127:0] SCT_predDest_p_i,
    input  logic [127:0] inst_rdata_i,
    input  logic         flush_w_i,
    input  logic         ID_allowin_w_i,
    output logic         IQ_allowin_w_o,
    output logic [1:0]   IQ_valid_o,
    output logic [63:0]  IQ_inst_o,
    output logic [63:0]  IQ_pc_o,
    output logic [1:0]   IQ_hasException_o,
    output logic [9:0]   IQ_ExcCode_o,
    output logic [1:0]   IQ_isRefill_o,
    output logic [1:0]   IQ_predTake_o,
    output logic [63:0]  IQ_predDest_o
);

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W:0]   count_reg, count_next;

    iq_entry_t mem [DEPTH];

    logic                      enq_fire;
    logic                      deq_fire;
    logic [2:0]                enq_n;
    logic [2:0]                deq_n;
    logic [2:0]                mask_total;
    logic [INST_NUM-1:0][1:0]  lane_offset;
    logic [3:0][1:0]           deq_offset_unused;
    logic                      unused_vaddr;

    iq_entry_t              lane_entry [INST_NUM];
    logic [INST_NUM-1:0]    lane_we;
    logic [PTR_W-1:0]       lane_addr  [INST_NUM];

    assign unused_vaddr = ^SCT_VAddr_i[1:0];

    inst_queue_compact u_enq_compact (
        .mask   (SCT_originEnable_i),
        .offset (lane_offset),
        .total  (mask_total)
    );

    inst_queue_compact u_deq_compact (
        .mask   ({2'b00, IQ_valid_o}),
        .offset (deq_offset_unused),
        .total  (deq_n)
    );

    assign IQ_allowin_w_o = (count_reg <= (PTR_W+1)'(DEPTH - 4));
    assign IQ_valid_o     = {count_reg >= (PTR_W+1)'(2), count_reg >= (PTR_W+1)'(1)};

    // A packet offered while allowin is low is dropped rather than overflowing.
    assign enq_fire = SCT_valid_i && IQ_allowin_w_o && !flush_w_i;
    assign deq_fire = ID_allowin_w_i && !flush_w_i;
    assign enq_n    = !enq_fire ? 3'd0 : (SCT_hasException_i ? 3'd1 : mask_total);

    genvar gi;
    generate
        for (gi = 0; gi < INST_NUM; gi++) begin : g_lane
            // An exception packet collapses to the single faulting lane written at tail.
            always_comb begin
                lane_entry[gi]           = '0;
                lane_entry[gi].pc        = {SCT_VAddr_i[31:4], 2'(gi), 2'b00};
                lane_entry[gi].exc_code  = NOEXCCODE;
                if (SCT_hasException_i) begin
                    lane_entry[gi].inst      = ZEROWORD;
                    lane_entry[gi].has_exc   = TRUE;
                    lane_entry[gi].exc_code  = SCT_ExcCode_i;
                    lane_entry[gi].is_refill = SCT_isRefill_i;
                    lane_entry[gi].pred_take = FALSE;
                    lane_we[gi]   = enq_fire && (SCT_VAddr_i[3:2] == 2'(gi));
                    lane_addr[gi] = tail_reg;
                end else begin
                    lane_entry[gi].inst      = inst_rdata_i[32*gi +: 32];
                    lane_entry[gi].pred_take = SCT_predTake_p_i[gi];
                    lane_entry[gi].pred_dest = SCT_predDest_p_i[32*gi +: 32];
                    lane_we[gi]   = enq_fire && SCT_originEnable_i[gi];
                    lane_addr[gi] = tail_reg + PTR_W'(lane_offset[gi]);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < INST_NUM; i++) begin
            if (lane_we[i]) begin
                mem[lane_addr[i]] <= lane_entry[i];
            end
        end
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush_w_i) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (deq_fire) begin
                head_next = head_reg + PTR_W'(deq_n);
            end
            tail_next  = tail_reg + PTR_W'(enq_n);
            count_next = count_reg + (PTR_W+1)'(enq_n)
                       - (deq_fire ? (PTR_W+1)'(deq_n) : '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            iq_entry_t slot_entry;
            assign slot_entry = IQ_valid_o[gi] ? mem[head_reg + PTR_W'(gi)] : '0;

            assign IQ_inst_o[32*gi +: 32]   = slot_entry.inst;
            assign IQ_pc_o[32*gi +: 32]     = slot_entry.pc;
            assign IQ_hasException_o[gi]    = slot_entry.has_exc;
            assign IQ_ExcCode_o[5*gi +: 5]  = slot_entry.exc_code;
            assign IQ_isRefill_o[gi]        = slot_entry.is_refill;
            assign IQ_predTake_o[gi]        = slot_entry.pred_take;
            assign IQ_predDest_o[32*gi +: 32] = slot_entry.pred_dest;
        end
    endgenerate

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue: reset, compaction, full/allowin,
// exception packets, flush priority and a long wrap-around stream against a model.
module tb_inst_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         SCT_valid_i;
    logic [3:0]   SCT_originEnable_i;
    logic [31:0]  SCT_VAddr_i;
    logic         SCT_hasException_i;
    logic [4:0]   SCT_ExcCode_i;
    logic         SCT_isRefill_i;
    logic [3:0]   SCT_predTake_p_i;
    logic [127:0] SCT_predDest_p_i;
    logic [127:0] inst_rdata_i;
    logic         flush_w_i;
    logic         ID_allowin_w_i;
    logic         IQ_allowin_w_o;
    logic [1:0]   IQ_valid_o;
    logic [63:0]  IQ_inst_o;
    logic [63:0]  IQ_pc_o;
    logic [1:0]   IQ_hasException_o;
    logic [9:0]   IQ_ExcCode_o;
    logic [1:0]   IQ_isRefill_o;
    logic [1:0]   IQ_predTake_o;
    logic [63:0]  IQ_predDest_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t model_q[$];

    always #5 clk = ~clk;

    inst_queue dut (
        .clk                (clk),
        .rst                (rst),
        .SCT_valid_i        (SCT_valid_i),
        .SCT_originEnable_i (SCT_originEnable_i),
        .SCT_VAddr_i        (SCT_VAddr_i),
        .SCT_hasException_i (SCT_hasException_i),
        .SCT_ExcCode_i      (SCT_ExcCode_i),
        .SCT_isRefill_i     (SCT_isRefill_i),
        .SCT_predTake_p_i   (SCT_predTake_p_i),
        .SCT_predDest_p_i   (SCT_predDest_p_i),
        .inst_rdata_i       (inst_rdata_i),
        .flush_w_i          (flush_w_i),
        .ID_allowin_w_i     (ID_allowin_w_i),
        .IQ_allowin_w_o     (IQ_allowin_w_o),
        .IQ_valid_o         (IQ_valid_o),
        .IQ_inst_o          (IQ_inst_o),
        .IQ_pc_o            (IQ_pc_o),
        .IQ_hasException_o  (IQ_hasException_o),
        .IQ_ExcCode_o       (IQ_ExcCode_o),
        .IQ_isRefill_o      (IQ_isRefill_o),
        .IQ_predTake_o      (IQ_predTake_o),
        .IQ_predDest_o      (IQ_predDest_o)
    );

    function automatic logic [31:0] lane_word(input logic [31:0] va, input int i);
        return {8'hC0 + 8'(i), 8'h5A, va[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        SCT_valid_i        = 1'b0;
        SCT_originEnable_i = 4'b0000;
        SCT_VAddr_i        = '0;
        SCT_hasException_i = 1'b0;
        SCT_ExcCode_i      = '0;
        SCT_isRefill_i     = 1'b0;
        SCT_predTake_p_i   = '0;
        SCT_predDest_p_i   = '0;
        inst_rdata_i       = '0;
        flush_w_i          = 1'b0;
        ID_allowin_w_i     = 1'b0;
    endtask

    // Sets packet inputs (valid asserted); caller decides when to step.
    task automatic drive_packet(input logic [31:0] va, input logic [3:0] mask,
                                input logic exc, input logic [4:0] code, input logic refill);
        SCT_valid_i        = 1'b1;
        SCT_originEnable_i = mask;
        SCT_VAddr_i        = va;
        SCT_hasException_i = exc;
        SCT_ExcCode_i      = code;
        SCT_isRefill_i     = refill;
        SCT_predTake_p_i   = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            inst_rdata_i[32*i +: 32]     = lane_word(va, i);
            SCT_predDest_p_i[32*i +: 32] = va + 32'h100 * (i + 1);
        end
    endtask

    task automatic push(input logic [31:0] va, input logic [3:0] mask);
        drive_packet(va, mask, 1'b0, 5'h0, 1'b0);
        step();
        SCT_valid_i = 1'b0;
    endtask

    task automatic flush_all();
        flush_w_i = 1'b1;
        step();
        flush_w_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (IQ_valid_o !== 2'b00) begin
            errors++; $display("FAIL reset_valid got %b want 00", IQ_valid_o);
        end
        checks++;
        if (IQ_allowin_w_o !== 1'b1) begin
            errors++; $display("FAIL reset_allowin got %b want 1", IQ_allowin_w_o);
        end
        checks++;
        if (IQ_pc_o !== 64'h0 || IQ_inst_o !== 64'h0 || IQ_predDest_o !== 64'h0) begin
            errors++; $display("FAIL reset_data got pc %h inst %h want zero", IQ_pc_o, IQ_inst_o);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        push(32'h0000_1000, 4'b1111);
        checks++;
        if (IQ_valid_o !== 2'b11) begin
            errors++; $display("FAIL basic_valid got %b want 11", IQ_valid_o);
        end
        checks++;
        if (IQ_pc_o !== {32'h0000_1004, 32'h0000_1000}) begin
            errors++; $display("FAIL basic_pc got %h want 0000100400001000", IQ_pc_o);
        end
        checks++;
        if (IQ_inst_o !== {lane_word(32'h1000, 1), lane_word(32'h1000, 0)}) begin
            errors++; $display("FAIL basic_inst got %h", IQ_inst_o);
        end
        checks++;
        if (IQ_predTake_o !== 2'b01 || IQ_predDest_o !== {32'h0000_1200, 32'h0000_1100}) begin
            errors++; $display("FAIL basic_pred got take %b dest %h want 01 0000120000001100",
                               IQ_predTake_o, IQ_predDest_o);
        end
        checks++;
        if (dut.count_reg !== 5'd4) begin
            errors++; $display("FAIL basic_count got %0d want 4", dut.count_reg);
        end
        ID_allowin_w_i = 1'b1;
        step();
        checks++;
        if (IQ_pc_o !== {32'h0000_100C, 32'h0000_1008} || IQ_valid_o !== 2'b11) begin
            errors++; $display("FAIL basic_deq1 got pc %h valid %b want 0000100c00001008 11",
                               IQ_pc_o, IQ_valid_o);
        end
        step();
        ID_allowin_w_i = 1'b0;
        checks++;
        if (IQ_valid_o !== 2'b00 || IQ_pc_o !== 64'h0) begin
            errors++; $display("FAIL basic_empty got valid %b pc %h want 00 0", IQ_valid_o, IQ_pc_o);
        end
    endtask

    task automatic test_compact();
        push(32'h0000_2000, 4'b1010);
        checks++;
        if (IQ_pc_o !== {32'h0000_200C, 32'h0000_2004}) begin
            errors++; $display("FAIL compact_pc got %h want 0000200c00002004", IQ_pc_o);
        end
        checks++;
        if (IQ_inst_o !== {lane_word(32'h2000, 3), lane_word(32'h2000, 1)}) begin
            errors++; $display("FAIL compact_inst got %h", IQ_inst_o);
        end
        checks++;
        if (dut.count_reg !== 5'd2 || IQ_valid_o !== 2'b11) begin
            errors++; $display("FAIL compact_count got %0d valid %b want 2 11",
                               dut.count_reg, IQ_valid_o);
        end
        ID_allowin_w_i = 1'b1;
        step();
        ID_allowin_w_i = 1'b0;
    endtask

    task automatic test_full();
        push(32'h0000_4000, 4'b1111);
        push(32'h0000_4010, 4'b1111);
        push(32'h0000_4020, 4'b1111);
        checks++;
        if (IQ_allowin_w_o !== 1'b1) begin
            errors++; $display("FAIL full_allow12 got %b want 1", IQ_allowin_w_o);
        end
        push(32'h0000_4030, 4'b0001);
        checks++;
        if (IQ_allowin_w_o !== 1'b0) begin
            errors++; $display("FAIL full_allow13 got %b want 0", IQ_allowin_w_o);
        end
        checks++;
        if (dut.count_reg !== 5'd13) begin
            errors++; $display("FAIL full_count got %0d want 13", dut.count_reg);
        end
        ID_allowin_w_i = 1'b1;
        step();
        ID_allowin_w_i = 1'b0;
        checks++;
        if (IQ_allowin_w_o !== 1'b1) begin
            errors++; $display("FAIL full_allow11 got %b want 1", IQ_allowin_w_o);
        end
        checks++;
        if (IQ_pc_o !== {32'h0000_400C, 32'h0000_4008}) begin
            errors++; $display("FAIL full_head got %h want 0000400c00004008", IQ_pc_o);
        end
        flush_all();
        checks++;
        if (IQ_valid_o !== 2'b00 || IQ_allowin_w_o !== 1'b1) begin
            errors++; $display("FAIL full_flush got valid %b allow %b want 00 1",
                               IQ_valid_o, IQ_allowin_w_o);
        end
    endtask

    task automatic test_exception();
        drive_packet(32'h0000_3008, 4'b1111, 1'b1, 5'h02, 1'b1);
        step();
        SCT_valid_i = 1'b0;
        checks++;
        if (IQ_valid_o !== 2'b01 || dut.count_reg !== 5'd1) begin
            errors++; $display("FAIL exc_valid got %b count %0d want 01 1", IQ_valid_o, dut.count_reg);
        end
        checks++;
        if (IQ_pc_o !== 64'h0000_0000_0000_3008 || IQ_inst_o !== 64'h0) begin
            errors++; $display("FAIL exc_pc_inst got pc %h inst %h want 3008 0", IQ_pc_o, IQ_inst_o);
        end
        checks++;
        if (IQ_hasException_o !== 2'b01 || IQ_ExcCode_o !== 10'h002 ||
            IQ_isRefill_o !== 2'b01 || IQ_predTake_o !== 2'b00) begin
            errors++; $display("FAIL exc_side got exc %b code %h refill %b take %b want 01 002 01 00",
                               IQ_hasException_o, IQ_ExcCode_o, IQ_isRefill_o, IQ_predTake_o);
        end
        ID_allowin_w_i = 1'b1;
        step();
        ID_allowin_w_i = 1'b0;
        checks++;
        if (IQ_valid_o !== 2'b00) begin
            errors++; $display("FAIL exc_drain got %b want 00", IQ_valid_o);
        end
    endtask

    task automatic test_flush();
        push(32'h0000_5000, 4'b1111);
        push(32'h0000_5010, 4'b0011);
        checks++;
        if (dut.count_reg !== 5'd6) begin
            errors++; $display("FAIL flush_pre got %0d want 6", dut.count_reg);
        end
        drive_packet(32'h0000_6000, 4'b1111, 1'b0, 5'h0, 1'b0);
        ID_allowin_w_i = 1'b1;
        flush_w_i      = 1'b1;
        step();
        SCT_valid_i    = 1'b0;
        ID_allowin_w_i = 1'b0;
        flush_w_i      = 1'b0;
        checks++;
        if (IQ_valid_o !== 2'b00 || dut.count_reg !== 5'd0 || IQ_allowin_w_o !== 1'b1) begin
            errors++; $display("FAIL flush_clear got valid %b count %0d allow %b want 00 0 1",
                               IQ_valid_o, dut.count_reg, IQ_allowin_w_o);
        end
        push(32'h0000_7000, 4'b0001);
        checks++;
        if (IQ_valid_o !== 2'b01 || IQ_pc_o !== 64'h0000_0000_0000_7000 ||
            IQ_inst_o[31:0] !== lane_word(32'h7000, 0)) begin
            errors++; $display("FAIL flush_after got valid %b pc %h want 01 7000", IQ_valid_o, IQ_pc_o);
        end
        flush_all();
    endtask

    task automatic test_stream();
        logic [1:0]  exp_v;
        logic [3:0]  mask;
        logic [31:0] va;
        logic        exc, snd, take, exp_allow;
        int          npop;
        model_q.delete();
        for (int k = 0; k < 150; k++) begin
            exp_v = (model_q.size() >= 2) ? 2'b11 : (model_q.size() == 1) ? 2'b01 : 2'b00;
            checks++;
            if (IQ_valid_o !== exp_v) begin
                errors++; $display("FAIL stream_valid k=%0d got %b want %b", k, IQ_valid_o, exp_v);
            end
            if (model_q.size() >= 1) begin
                checks++;
                if (IQ_pc_o[31:0] !== model_q[0].pc || IQ_inst_o[31:0] !== model_q[0].inst) begin
                    errors++; $display("FAIL stream_slot0 k=%0d got %h/%h want %h/%h", k,
                                       IQ_pc_o[31:0], IQ_inst_o[31:0], model_q[0].pc, model_q[0].inst);
                end
            end
            if (model_q.size() >= 2) begin
                checks++;
                if (IQ_pc_o[63:32] !== model_q[1].pc || IQ_inst_o[63:32] !== model_q[1].inst) begin
                    errors++; $display("FAIL stream_slot1 k=%0d got %h/%h want %h/%h", k,
                                       IQ_pc_o[63:32], IQ_inst_o[63:32], model_q[1].pc, model_q[1].inst);
                end
            end
            exp_allow = (model_q.size() <= 12);
            checks++;
            if (IQ_allowin_w_o !== exp_allow) begin
                errors++; $display("FAIL stream_allow k=%0d got %b want %b", k, IQ_allowin_w_o, exp_allow);
            end

            mask = 4'((k * 7 + 3) % 16);
            exc  = (k % 9 == 4);
            va   = 32'h8000_0000 + 32'(k * 16) + (exc ? 32'((k % 4) * 4) : 32'h0);
            snd  = exp_allow && (k % 5 != 2);
            take = (k % 3 != 0);
            drive_packet(va, mask, exc, 5'h03, 1'b0);
            SCT_valid_i    = snd;
            ID_allowin_w_i = take;
            step();

            if (take) begin
                npop = (model_q.size() >= 2) ? 2 : model_q.size();
                for (int p = 0; p < npop; p++) void'(model_q.pop_front());
            end
            if (snd) begin
                if (exc) begin
                    model_q.push_back('{pc: va, inst: 32'h0});
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (mask[i]) model_q.push_back('{pc: {va[31:4], 4'(i * 4)},
                                                         inst: lane_word(va, i)});
                    end
                end
            end
        end
        SCT_valid_i    = 1'b0;
        ID_allowin_w_i = 1'b1;
        for (int d = 0; d < 12 && model_q.size() > 0; d++) begin
            checks++;
            if (IQ_pc_o[31:0] !== model_q[0].pc || IQ_valid_o[0] !== 1'b1) begin
                errors++; $display("FAIL stream_drain d=%0d got %h valid %b want %h", d,
                                   IQ_pc_o[31:0], IQ_valid_o, model_q[0].pc);
            end
            step();
            npop = (model_q.size() >= 2) ? 2 : model_q.size();
            for (int p = 0; p < npop; p++) void'(model_q.pop_front());
        end
        ID_allowin_w_i = 1'b0;
        checks++;
        if (IQ_valid_o !== 2'b00 || model_q.size() != 0) begin
            errors++; $display("FAIL stream_end got valid %b model left %0d want 00 0",
                               IQ_valid_o, model_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_compact();
        test_full();
        test_exception();
        test_flush();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
